instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
Inverse of the immediate/instruction decode path. It accepts field-level instruction requests (op, rd, rs1, rs2, 64-bit immediate) and packs them into 32-bit RV64 machine words for ld, sd, beq and add. Words are buffered in a FIFO and emitted with an incrementing instruction-memory word address. The block sits in the program-loader path that fills instruction memory for the sequential processor and its tests.

Parameters:
DEPTH, 4, FIFO entries (power of 2, ≥2)
ADDR_W, 32, width of out_addr
BASE_ADDR, 0, address of first emitted word after reset/restart

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
restart  in  1  pulse: flush FIFO, reload address to BASE_ADDR
in_valid  in  1  request valid
in_ready  out  1  FIFO can accept
in_op  in  2  00 ld, 01 sd, 10 beq, 11 add
in_rd  in  5  destination reg (ld, add)
in_rs1  in  5  source 1 (all ops)
in_rs2  in  5  source 2 (sd, beq, add)
in_imm  in  64  sign-extended immediate; beq value is halfword-scaled offset
out_valid  out  1  encoded word available
out_ready  in  1  consumer accepts
out_instr  out  32  encoded instruction
out_addr  out  ADDR_W  byte address for out_instr
out_err  out  1  immediate out of 12-bit signed range (feature only)
level  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Reset values: all outputs 0 (in_ready=0, out_valid=0, out_instr=0, out_err=0, level=0), out_addr=BASE_ADDR, FIFO pointers 0. in_ready rises the cycle after reset deasserts.
- Encoding uses imm12 = in_imm[11:0]. Unused fields are 0.
  - ld: {imm12, rs1, 3'b011, rd, 7'b0000011}
  - sd: {imm12[11:5], rs2, rs1, 3'b011, imm12[4:0], 7'b0100011}
  - beq: inst[31]=imm12[11], inst[30:25]=imm12[9:4], rs2, rs1, 3'b000, inst[11:8]=imm12[3:0], inst[7]=imm12[10], 7'b1100011
  - add: {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011}
  - Round trip: for in-range imm, the team's immediate decoder returns in_imm exactly.
- Input handshake: accept when in_valid&&in_ready. in_ready = !full && !restart. The encoded word is written to the FIFO that edge. There is no bypass, so the earliest out_valid is the next cycle (latency 1).
- Output handshake: out_valid = !empty. out_instr, out_err and out_addr are stable while out_valid&&!out_ready. On pop, out_addr += 4, wrapping mod 2^ADDR_W.
- Simultaneous push and pop:
  - Not full: both occur and level is unchanged.
  - Full: pop only, because in_ready is already low. In_ready rises the next cycle.
- Pointers are log2(DEPTH) bits and wrap naturally. Full/empty are derived from the level counter.
- restart: next edge sets level=0, pointers=0, out_addr=BASE_ADDR, out_valid=0. A same-cycle push or pop is discarded. reset has priority over restart.
- Reset mid-transfer drops all buffered words. No partial state survives.

Optional Feature:
IMM_RANGE_CHECK_EN
- Defined: each entry stores err = (in_imm != sign-extension of in_imm[11:0]); ld/sd/beq only, add always 0. The word is still encoded from the truncated imm12. out_err accompanies its word.
- Undefined: no check, no storage bit; out_err tied 0.

Decomposition:
- Package instr_enc_pkg holds:
  - op codes (OP_LD, OP_SD, OP_BEQ, OP_ADD)
  - 7-bit opcode constants
  - funct3 constants (F3_D=011, F3_BEQ=000)
  - encoding function encode_instr(op, rd, rs1, rs2, imm12)
- Sub-module instr_enc_fifo: a parameterised synchronous FIFO (data width 32 or 33, DEPTH) with level output. The top level is the encoder plus address counter.

Test Plan:
- ld rd=5 rs1=2 imm=8 → out_instr 0x00813283 at out_addr BASE_ADDR, out_valid the cycle after accept.
- sd rs2=6 rs1=2 imm=-4 then beq rs1=1 rs2=2 imm=-2 back-to-back, out_ready=1 → 0xFE613E23 @0, 0xFE208EE3 @4. Decoder round-trip returns -4 and -2.
- add rd=3 rs1=1 rs2=2 with out_ready=0 for DEPTH+2 pushes → in_ready low after DEPTH accepts, level=DEPTH. Release out_ready → DEPTH words 0x002081B3 at addresses 0,4,8,12 in order, no loss or duplication.
- Full FIFO with in_valid=1 and out_ready=1 the same cycle → pop only; level DEPTH-1; in_ready high next cycle.
- restart asserted with in_valid=1 and 3 words queued → level=0, out_valid=0, out_addr=BASE_ADDR next cycle. The request is not accepted, and the next word emitted is at BASE_ADDR.
- With IMM_RANGE_CHECK_EN, ld imm=2048 → out_err=1, out_instr imm field 0x800; imm=-2048 → out_err=0. Without the macro, out_err=0 for both.

Source files
------------

// File: rtl/instr_enc_pkg.sv
// rtl/instr_enc_pkg.sv - op codes, RV64 opcode/funct3 constants and the field packer for ld/sd/beq/add
package instr_enc_pkg;

  typedef enum logic [1:0] {
    OP_LD  = 2'b00,
    OP_SD  = 2'b01,
    OP_BEQ = 2'b10,
    OP_ADD = 2'b11
  } op_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_D   = 3'b011;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_ADD = 3'b000;

  // beq imm12 is already halfword-scaled, so imm12[k] lands where byte-offset bit k+1 would
  function automatic logic [31:0] encode_instr(op_t op, logic [4:0] rd, logic [4:0] rs1,
                                               logic [4:0] rs2, logic [11:0] imm12);
    logic [31:0] w;
    case (op)
      OP_LD:   w = {imm12, rs1, F3_D, rd, OPC_LOAD};
      OP_SD:   w = {imm12[11:5], rs2, rs1, F3_D, imm12[4:0], OPC_STORE};
      OP_BEQ:  w = {imm12[11], imm12[9:4], rs2, rs1, F3_BEQ, imm12[3:0], imm12[10], OPC_BRANCH};
      default: w = {7'b0, rs2, rs1, F3_ADD, rd, OPC_OP};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/instr_enc_fifo.sv
// rtl/instr_enc_fifo.sv - synchronous FIFO with occupancy counter; full/empty come from the level
module instr_enc_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == (PW + 1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (PW + 1)'(1);
        2'b01:   level <= level - (PW + 1)'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Storage is never reset, so the read port is masked while nothing valid is held
  assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - packs field requests into RV64 words, buffers them, emits with word addresses; optional IMM_RANGE_CHECK_EN
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter int                DEPTH     = 4,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   restart,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_op,
  input  logic [4:0]             in_rd,
  input  logic [4:0]             in_rs1,
  input  logic [4:0]             in_rs2,
  input  logic [63:0]            in_imm,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_instr,
  output logic [ADDR_W-1:0]      out_addr,
  output logic                   out_err,
  output logic [$clog2(DEPTH):0] level
);

`ifdef IMM_RANGE_CHECK_EN
  localparam int DW = 33;
`else
  localparam int DW = 32;
`endif

  logic          ready_en;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [31:0]   word;
  logic [DW-1:0] push_data;
  logic [DW-1:0] pop_data;

  assign word = encode_instr(op_t'(in_op), in_rd, in_rs1, in_rs2, in_imm[11:0]);

`ifdef IMM_RANGE_CHECK_EN
  logic imm_err;
  assign imm_err   = (op_t'(in_op) != OP_ADD) && (in_imm != {{52{in_imm[11]}}, in_imm[11:0]});
  assign push_data = {imm_err, word};
  assign out_err   = pop_data[32];
`else
  logic unused_imm_hi;
  assign unused_imm_hi = ^in_imm[63:12];
  assign push_data     = word;
  assign out_err       = 1'b0;
`endif

  // Holds in_ready low through reset and for the first cycle after it
  always_ff @(posedge clk) begin
    if (reset) ready_en <= 1'b0;
    else       ready_en <= 1'b1;
  end

  assign in_ready  = ready_en && !full && !restart;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !restart;
  assign out_instr = pop_data[31:0];

  instr_enc_fifo #(.DEPTH(DEPTH), .W(DW)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (restart),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  always_ff @(posedge clk) begin
    if (reset || restart) out_addr <= BASE_ADDR;
    else if (pop)         out_addr <= out_addr + ADDR_W'(4);
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - scoreboard bench for instr_encoder: directed cases then randomized traffic vs a field-level model
module tb_instr_encoder;

  localparam int DEPTH = 4;
`ifdef IMM_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, restart, in_valid, in_ready, out_valid, out_ready, out_err;
  logic [1:0]  in_op;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [63:0] in_imm;
  logic [31:0] out_instr, out_addr;
  logic [$clog2(DEPTH):0] level;

  always #5 clk = ~clk;

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(32), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .reset(reset), .restart(restart), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
    .out_err(out_err), .level(level)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
    logic [1:0]  op;
    logic [63:0] imm;
    logic        in_range;
  } exp_t;

  exp_t        q[$];
  int unsigned n_pushed = 0;
  int          acc_cnt = 0;
  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [31:0] force_word = '0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [63:0] sext12(logic [63:0] v);
    return {{52{v[11]}}, v[11:0]};
  endfunction

  // Standard R/I/S/B layouts built by shifting fields into place; beq offset doubled to bytes
  function automatic logic [31:0] model_word(logic [1:0] op, logic [31:0] rd, logic [31:0] rs1,
                                             logic [31:0] rs2, logic [63:0] imm);
    logic [31:0] i, off;
    i   = {20'b0, imm[11:0]};
    off = i << 1;
    case (op)
      2'd0:    return (i << 20) | (rs1 << 15) | (32'd3 << 12) | (rd << 7) | 32'h03;
      2'd1:    return ((i >> 5) << 25) | (rs2 << 20) | (rs1 << 15) | (32'd3 << 12)
                      | ((i & 32'd31) << 7) | 32'h23;
      2'd2:    return (((off >> 12) & 32'd1) << 31) | (((off >> 5) & 32'd63) << 25) | (rs2 << 20)
                      | (rs1 << 15) | (((off >> 1) & 32'd15) << 8) | (((off >> 11) & 32'd1) << 7)
                      | 32'h63;
      default: return (rs2 << 20) | (rs1 << 15) | (rd << 7) | 32'h33;
    endcase
  endfunction

  function automatic logic [63:0] decode_imm(logic [31:0] w, logic [1:0] op);
    logic [63:0] off;
    off = {{51{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    case (op)
      2'd0:    return sext12({52'b0, w[31:20]});
      2'd1:    return sext12({52'b0, w[31:25], w[11:7]});
      default: return $signed(off) >>> 1;
    endcase
  endfunction

  // Accept model: decides at the falling edge what the next rising edge will do
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (reset || restart) begin
      q.delete();
      n_pushed = 0;
    end else if (in_valid && in_ready) begin
      e.instr    = (force_word != 0) ? force_word
                                     : model_word(in_op, {27'b0, in_rd}, {27'b0, in_rs1},
                                                  {27'b0, in_rs2}, in_imm);
      e.addr     = 32'(n_pushed * 4);
      e.in_range = (in_imm == sext12(in_imm));
      e.err      = RC && (in_op != 2'd3) && !e.in_range;
      e.op       = in_op;
      e.imm      = in_imm;
      q.push_back(e);
      n_pushed++;
      acc_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(logic [1:0] op, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                         logic [63:0] imm);
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (q.size() == 0 && !out_valid) break;
      step();
    end
    check("drain_empty", 64'(q.size()) | 64'(out_valid), 64'd0);
  endtask

  // Monitor: every accepted output word is matched against the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (!reset && !restart && out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("unexpected_word", {32'b0, out_instr}, 64'hDEAD);
      end else begin
        e = q.pop_front();
        check("out_instr", {32'b0, out_instr}, {32'b0, e.instr});
        check("out_addr", {32'b0, out_addr}, {32'b0, e.addr});
        check("out_err", {63'b0, out_err}, {63'b0, e.err});
        if (e.op != 2'd3 && e.in_range)
          check("roundtrip_imm", decode_imm(out_instr, e.op), e.imm);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; restart = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_req(2'd0, 5'd0, 5'd0, 5'd0, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {63'b0, in_ready}, 64'd0);
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_out_instr", {32'b0, out_instr}, 64'd0);
    check("rst_out_err", {63'b0, out_err}, 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_out_addr", {32'b0, out_addr}, 64'd0);
    reset = 1'b0;
    #1;
    check("in_ready_held_low", {63'b0, in_ready}, 64'd0);
    step();
    check("in_ready_rises", {63'b0, in_ready}, 64'd1);

    // ld, then sd/beq back-to-back
    set_req(2'd0, 5'd5, 5'd2, 5'd0, 64'd8);
    force_word = 32'h00813283; in_valid = 1'b1;
    step();
    in_valid = 1'b0; force_word = '0;
    check("ld_latency", {63'b0, out_valid}, 64'd1);
    out_ready = 1'b1;
    set_req(2'd1, 5'd0, 5'd2, 5'd6, -64'sd4);
    force_word = 32'hFE613E23; in_valid = 1'b1;
    step();
    set_req(2'd2, 5'd0, 5'd1, 5'd2, -64'sd2);
    force_word = 32'hFE208EE3;
    step();
    in_valid = 1'b0; force_word = '0;
    drain();
    restart = 1'b1;
    step();
    restart = 1'b0;
    check("restart_addr", {32'b0, out_addr}, 64'd0);

    // Fill to full with the consumer stalled, then pop with a push pending
    out_ready = 1'b0; acc_cnt = 0;
    set_req(2'd3, 5'd3, 5'd1, 5'd2, 64'd0);
    force_word = 32'h002081B3; in_valid = 1'b1;
    repeat (DEPTH + 2) step();
    check("fill_accepts", 64'(acc_cnt), 64'(DEPTH));
    check("fill_level", 64'(level), 64'(DEPTH));
    check("fill_in_ready", {63'b0, in_ready}, 64'd0);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0; force_word = '0;
    check("full_pop_level", 64'(level), 64'(DEPTH - 1));
    check("full_pop_in_ready", {63'b0, in_ready}, 64'd1);
    drain();

    // restart with three words queued and a request pending
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_req(2'd0, 5'(i + 1), 5'd4, 5'd0, 64'(i * 8));
      step();
    end
    restart = 1'b1;
    #1;
    check("restart_blocks_in", {63'b0, in_ready}, 64'd0);
    step();
    restart = 1'b0; in_valid = 1'b0;
    check("restart_level", 64'(level), 64'd0);
    check("restart_out_valid", {63'b0, out_valid}, 64'd0);
    check("restart_out_addr", {32'b0, out_addr}, 64'd0);
    set_req(2'd0, 5'd7, 5'd8, 5'd0, 64'd16);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    drain();

    // 12-bit range boundaries: both encode imm field 0x800
    set_req(2'd0, 5'd1, 5'd1, 5'd0, 64'd2048);
    force_word = 32'h8000B083; in_valid = 1'b1;
    step();
    set_req(2'd0, 5'd1, 5'd1, 5'd0, -64'sd2048);
    step();
    in_valid = 1'b0; force_word = '0;
    drain();

    // Randomized traffic
    for (int c = 0; c < 500; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      restart   = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 3) != 0)
        set_req(2'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                64'(longint'($urandom_range(0, 4095)) - 64'sd2048));
      else
        set_req(2'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), {$urandom, $urandom});
      step();
    end
    in_valid = 1'b0; restart = 1'b0; out_ready = 1'b1;
    drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
